// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
//   master : operand source and result sink (drives in_valid/A/B/Cin/sub/out_ready)
//   slave  : the adder (drives in_ready/out_valid/Sum/Cout/ovf)
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Sum, Cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. WIDTH-bit operands are split into
// BLOCK-bit lookahead groups; one group is resolved per stage and the group carry
// ripples stage to stage. Valid/ready flow control with a global stall.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of pipelined_cla_adder_if (operands in, results out)
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    pipelined_cla_adder_if.slave    bus
);
    localparam int unsigned NUM_BLK = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > 8) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK in 2..8");
    end

    typedef struct packed {
        logic             cout;   // carry out of the group
        logic             cmsb;   // carry into the group's top bit
        logic [BLOCK-1:0] sum;
    } grp_t;

    // One lookahead group: every carry is a sum-of-products of g/p and cin.
    function automatic grp_t cla_group(input logic [BLOCK-1:0] a,
                                       input logic [BLOCK-1:0] b,
                                       input logic             cin);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             prod;
        grp_t             r;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BLOCK); i++) begin
            prod = 1'b1;
            for (int m = i; m >= 0; m--) begin
                c[i+1] = c[i+1] | (g[m] & prod);
                prod   = prod & p[m];
            end
            c[i+1] = c[i+1] | (prod & cin);
        end
        r.sum  = p ^ c[BLOCK-1:0];
        r.cout = c[BLOCK];
        r.cmsb = c[BLOCK-1];
        return r;
    endfunction

    // Stage k holds: valid, carry into group k, partial sum of groups < k.
    logic             v_q [0:NUM_BLK];
    logic             c_q [0:NUM_BLK];
    logic [WIDTH-1:0] s_q [0:NUM_BLK];
    logic [WIDTH-1:0] a_q [0:NUM_BLK-1];
    logic [WIDTH-1:0] b_q [0:NUM_BLK-1];
    logic             ovf_q;
    grp_t             grp [1:NUM_BLK];
    logic             stall;
    logic             advance;

    assign stall   = v_q[NUM_BLK] & ~bus.out_ready;
    assign advance = ~stall;

    // Group k-1 is resolved in the logic feeding stage k.
    always_comb begin
        for (int k = 1; k <= int'(NUM_BLK); k++) begin
            grp[k] = cla_group(a_q[k-1][(k-1)*BLOCK +: BLOCK],
                               b_q[k-1][(k-1)*BLOCK +: BLOCK],
                               c_q[k-1]);
        end
    end

    // Pipeline registers; data of a stage only moves when a valid op enters it,
    // so outputs hold their last result across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= int'(NUM_BLK); k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
            end
            for (int k = 0; k < int'(NUM_BLK); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
                a_q[0] <= bus.A;
                b_q[0] <= bus.sub ? ~bus.B : bus.B;
                c_q[0] <= bus.sub | bus.Cin;
                s_q[0] <= '0;
            end
            for (int k = 1; k <= int'(NUM_BLK); k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    c_q[k] <= grp[k].cout;
                    s_q[k] <= s_q[k-1];
                    s_q[k][(k-1)*BLOCK +: BLOCK] <= grp[k].sum;
                end
            end
            for (int k = 1; k < int'(NUM_BLK); k++) begin
                if (v_q[k-1]) begin
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
                end
            end
            if (v_q[NUM_BLK-1]) begin
                ovf_q <= grp[NUM_BLK].cmsb ^ grp[NUM_BLK].cout;
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[NUM_BLK];
    assign bus.Sum       = s_q[NUM_BLK];
    assign bus.Cout      = c_q[NUM_BLK];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, BLOCK=4): directed and random steps
// compared against an arithmetic model of a 5-slot result pipeline.
module tb_pipelined_cla_adder;
    localparam int N = 4;  // edges from accept to result

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_mis = 0;

    logic        m_v [0:N];
    logic [17:0] m_r [0:N];  // {Sum, Cout, ovf}

    pipelined_cla_adder_if #(.WIDTH(16)) bus ();

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic sb);
        logic [15:0] bp;
        logic [16:0] full;
        logic        ov;
        bp   = sb ? ~b : b;
        full = 17'(a) + 17'(bp) + 17'(sb ? 1'b1 : ci);
        ov   = (a[15] == bp[15]) && (full[15] != a[15]);
        return {full[15:0], full[16], ov};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model at posedge, check outputs.
    task automatic step(input logic rst, input logic iv, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input logic sb,
                        input logic orr);
        logic stall;
        logic acc;
        reset         = rst;
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.Cin       = ci;
        bus.sub       = sb;
        bus.out_ready = orr;
        #1;
        stall = m_v[N] && !orr;
        acc   = iv && !stall;
        if (!rst) check("in_ready", 32'(bus.in_ready), 32'(!stall));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k <= N; k++) begin
                m_v[k] = 1'b0;
                m_r[k] = '0;
            end
        end else if (!stall) begin
            for (int k = N; k >= 1; k--) begin
                if (m_v[k-1]) m_r[k] = m_r[k-1];
                m_v[k] = m_v[k-1];
            end
            m_v[0] = acc;
            if (acc) m_r[0] = ref_add(a, b, ci, sb);
        end
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(m_v[N]));
        check("Sum",       32'(bus.Sum),       32'(m_r[N][17:2]));
        check("Cout",      32'(bus.Cout),      32'(m_r[N][1]));
        check("ovf",       32'(bus.ovf),       32'(m_r[N][0]));
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        step(1'b0, 1'b1, a, b, ci, sb, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        for (int k = 0; k <= N; k++) begin
            m_v[k] = 1'b0;
            m_r[k] = '0;
        end
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset held three cycles, then released.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Single add with exact latency.
        op(16'h0001, 16'h0002, 1'b0, 1'b0);
        idle(6);

        // Carry / overflow edges.
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'h000F, 16'h0001, 1'b1, 1'b0);
        idle(6);

        // Eight back-to-back ops, subtract included.
        op(16'h0005, 16'h000A, 1'b1, 1'b1);
        op(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            op(ra, rb, 1'($urandom), 1'($urandom));
        end
        idle(6);

        // Backpressure with a full pipe.
        for (int i = 0; i < 5; i++) op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0);
        idle(7);

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        op(16'h1234, 16'h1111, 1'b1, 1'b0);
        idle(6);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       begin ra = 16'hFFFF; rb = 16'($urandom_range(0, 2)); end
                1:       begin ra = 16'h8000; rb = 16'h7FFF; end
                default: begin ra = 16'($urandom); rb = 16'($urandom); end
            endcase
            step(1'b0, 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
